// File: rtl/pcpi_pkg.sv
// Shared types and constants for the byte-serial PCPI initiator and the
// coprocessor side that answers it.
package pcpi_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int REQ_BYTES  = 12;
    localparam int RSP_BYTES  = 5;

    localparam int ST_READY   = 0;
    localparam int ST_WR      = 1;
    localparam int ST_TIMEOUT = 2;

    function automatic logic [7:0] make_status(input logic timeout, input logic wr,
                                               input logic ready);
        logic [7:0] s;
        s              = '0;
        s[ST_TIMEOUT]  = timeout;
        s[ST_WR]       = wr;
        s[ST_READY]    = ready;
        return s;
    endfunction

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// Wait/timeout rule for an outstanding PCPI request: counts unwaited cycles
// and flags the cycle on which the request becomes unclaimed.
module pcpi_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != CW'(TIMEOUT_CYCLES)) begin
            count <= count + 1'b1;
        end
    end

    // Fires during the cycle whose increment would reach the limit, so the
    // request is visible for exactly TIMEOUT_CYCLES unwaited cycles.
    assign expired = enable && !clear && (count >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pcpi_byte_initiator.sv
// Byte-serial PCPI initiator: gathers a 12-byte request, issues one PCPI
// transaction with timeout, and streams back a 5-byte response.
module pcpi_byte_initiator
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        busy
);

    state_t      state;
    logic [3:0]  byte_cnt;
    logic [2:0]  rsp_cnt;
    logic [31:0] rd_reg;
    logic        tmo_clear;
    logic        tmo_enable;
    logic        expired;

    assign tmo_enable = (state == ISSUE);
    assign tmo_clear  = (state != ISSUE) || pcpi_wait;

    pcpi_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            byte_cnt   <= '0;
            rsp_cnt    <= '0;
            rd_reg     <= '0;
            in_ready   <= 1'b1;
            out_data   <= '0;
            out_valid  <= 1'b0;
            pcpi_valid <= 1'b0;
            pcpi_insn  <= '0;
            pcpi_rs1   <= '0;
            pcpi_rs2   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        case (byte_cnt[3:2])
                            2'd0:    pcpi_insn[{byte_cnt[1:0], 3'b000} +: 8] <= in_data;
                            2'd1:    pcpi_rs1[{byte_cnt[1:0], 3'b000} +: 8]  <= in_data;
                            default: pcpi_rs2[{byte_cnt[1:0], 3'b000} +: 8]  <= in_data;
                        endcase
                        if (byte_cnt == 4'(REQ_BYTES - 1)) begin
                            byte_cnt   <= '0;
                            state      <= ISSUE;
                            in_ready   <= 1'b0;
                            pcpi_valid <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                // A claimed result takes priority over an expiry in the same cycle.
                ISSUE: begin
                    if (pcpi_ready || expired) begin
                        if (pcpi_ready) begin
                            rd_reg   <= pcpi_rd;
                            out_data <= make_status(1'b0, pcpi_wr, 1'b1);
                        end else begin
                            rd_reg   <= '0;
                            out_data <= make_status(1'b1, 1'b0, 1'b0);
                        end
                        pcpi_valid <= 1'b0;
                        out_valid  <= 1'b1;
                        rsp_cnt    <= '0;
                        state      <= RESP;
                    end
                end

                RESP: begin
                    if (out_valid && out_ready) begin
                        if (rsp_cnt == 3'(RSP_BYTES - 1)) begin
                            rsp_cnt   <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= LOAD;
                        end else begin
                            out_data <= rd_reg[{rsp_cnt[1:0], 3'b000} +: 8];
                            rsp_cnt  <= rsp_cnt + 1'b1;
                        end
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_pcpi_byte_initiator.sv
// Directed and randomized bench for pcpi_byte_initiator; expected responses
// and request durations come from a frame-level model of the PCPI rules.
module tb_pcpi_byte_initiator;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    pcpi_byte_initiator #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pcpi_valid(pcpi_valid),
        .pcpi_insn (pcpi_insn),
        .pcpi_rs1  (pcpi_rs1),
        .pcpi_rs2  (pcpi_rs2),
        .pcpi_wr   (pcpi_wr),
        .pcpi_rd   (pcpi_rd),
        .pcpi_wait (pcpi_wait),
        .pcpi_ready(pcpi_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks are entered and left right after a falling edge.
    task automatic apply_stimulus(input logic [31:0] insn, input logic [31:0] rs1,
                                  input logic [31:0] rs2);
        logic [95:0] frame;
        frame = {rs2, rs1, insn};
        for (int i = 0; i < 12; i++) begin
            check_output("load_in_ready", 32'(in_ready), 32'd1);
            if (i == 11) check_output("valid_before_last", 32'(pcpi_valid), 32'd0);
            in_valid = 1'b1;
            in_data  = frame[8*i +: 8];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_output("valid_rise", 32'(pcpi_valid), 32'd1);
        check_output("insn", pcpi_insn, insn);
        check_output("rs1", pcpi_rs1, rs1);
        check_output("rs2", pcpi_rs2, rs2);
    endtask

    // Responder plus reference model for one transaction; mode 0 = out_ready
    // high, 1 = 1-0-0-1 pattern with in_valid held, 2 = random out_ready.
    task automatic run_transaction(input logic [31:0] insn, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input int wait_len,
                                   input int ready_after, input logic wr,
                                   input logic [31:0] rd, input int mode);
        logic [7:0] exp_b [5];
        logic       claimed;
        int         exp_cycles;
        int         c;
        int         k;
        logic       r;
        logic [3:0] pat;

        claimed    = (ready_after >= 0) && (ready_after < TIMEOUT);
        exp_cycles = claimed ? wait_len + ready_after + 1 : wait_len + TIMEOUT;
        exp_b[0]   = claimed ? (wr ? 8'h03 : 8'h01) : 8'h04;
        for (int i = 0; i < 4; i++) exp_b[i+1] = claimed ? rd[8*i +: 8] : 8'h00;

        apply_stimulus(insn, rs1, rs2);

        c = 0;
        while (pcpi_valid === 1'b1 && c < 500) begin
            check_output("issue_busy", 32'(busy), 32'd1);
            check_output("issue_in_ready", 32'(in_ready), 32'd0);
            pcpi_wait  = (c < wait_len);
            pcpi_ready = (ready_after >= 0) && (c == wait_len + ready_after);
            pcpi_wr    = pcpi_ready ? wr : 1'($urandom);
            pcpi_rd    = pcpi_ready ? rd : $urandom;
            c++;
            @(negedge clk);
        end
        pcpi_ready = 1'b0;
        pcpi_wait  = 1'b0;
        check_output("valid_cycles", 32'(c), 32'(exp_cycles));
        check_output("out_valid_rise", 32'(out_valid), 32'd1);

        pat = 4'b1001;
        k   = 0;
        c   = 0;
        while (k < 5 && c < 200) begin
            check_output("resp_valid", 32'(out_valid), 32'd1);
            check_output($sformatf("resp_byte%0d", k), 32'(out_data), 32'(exp_b[k]));
            check_output("resp_in_ready", 32'(in_ready), 32'd0);
            case (mode)
                0:       r = 1'b1;
                1:       r = pat[3 - (c % 4)];
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (mode == 1) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end
            if (r) k++;
            c++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_output("resp_done", 32'(k), 32'd5);
        if (mode == 0) check_output("resp_cycles", 32'(c), 32'd5);
        check_output("idle_out_valid", 32'(out_valid), 32'd0);
        check_output("idle_in_ready", 32'(in_ready), 32'd1);
        check_output("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check_output({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_output({tag, "_out_data"}, 32'(out_data), 32'd0);
        check_output({tag, "_pcpi_valid"}, 32'(pcpi_valid), 32'd0);
        check_output({tag, "_insn"}, pcpi_insn, 32'd0);
        check_output({tag, "_rs1"}, pcpi_rs1, 32'd0);
        check_output({tag, "_rs2"}, pcpi_rs2, 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic op");
        run_transaction(32'h0200_00B3, 32'h7, 32'h6, 0, 3, 1'b1, 32'h2A, 0);

        $display("[TB] unclaimed instruction");
        run_transaction(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 0, -1, 1'b0, 32'h0, 0);

        $display("[TB] long wait");
        run_transaction(32'h0000_0033, 32'h1, 32'h2, 40, 0, 1'b0, 32'hDEAD_BEEF, 0);

        $display("[TB] ready on timeout cycle");
        run_transaction(32'h0200_00B3, 32'h3, 32'h4, 0, TIMEOUT - 1, 1'b1, 32'h0000_000C, 0);

        $display("[TB] backpressure");
        run_transaction(32'hCAFE_F00D, 32'h1111_2222, 32'h3333_4444, 2, 5, 1'b1, 32'h8765_4321, 1);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_values("mid_frame_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_transaction(32'h0200_00B3, 32'h7, 32'h6, 0, 3, 1'b1, 32'h2A, 0);

        $display("[TB] reset mid-transaction");
        apply_stimulus(32'hA5A5_5A5A, 32'h1, 32'h2);
        pcpi_wait = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_issue_rst");
        @(negedge clk);
        pcpi_wait = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 10; t++) begin
            int r;
            int ra;
            r  = int'($urandom_range(0, 24));
            ra = (r > 20) ? -1 : r;
            run_transaction($urandom, $urandom, $urandom, int'($urandom_range(0, 4)), ra,
                            1'($urandom), $urandom, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcpi_byte_initiator.md
# pcpi_byte_initiator

Byte-serial PCPI initiator that lets the 8-bit chip pins drive a PCPI coprocessor. It collects a 12-byte request frame (instruction, rs1, rs2) from a byte stream and issues one PCPI transaction. It applies the PicoRV32 wait/timeout rules and returns a 5-byte response frame (status, rd). It sits between the top-level pin wrapper and the coprocessor core, and is the requesting end of the PCPI link the coprocessor answers.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: cycles with pcpi_valid high, pcpi_ready low and pcpi_wait low before the request is declared unclaimed.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  request byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_data  out  8  response byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  byte consumed when out_valid && out_ready.
- pcpi_valid  out  1  request to coprocessor.
- pcpi_insn  out  32  instruction word.
- pcpi_rs1  out  32  operand 1.
- pcpi_rs2  out  32  operand 2.
- pcpi_wr  in  1  coprocessor writes rd; sampled with pcpi_ready.
- pcpi_rd  in  32  result; sampled with pcpi_ready.
- pcpi_wait  in  1  coprocessor busy; suspends the timeout.
- pcpi_ready  in  1  coprocessor done.
- busy  out  1  high in ISSUE and RESP.

## Operation
- States: LOAD → ISSUE → RESP → LOAD.
- LOAD:
  - in_ready=1; byte counter runs 0..11.
  - Bytes 0–3 fill insn, 4–7 fill rs1, 8–11 fill rs2, each little-endian (LSB first).
  - The accept of byte 11 moves the state to ISSUE.
- ISSUE:
  - pcpi_valid=1 and in_ready=0; insn, rs1 and rs2 stay stable.
  - Timeout counter clears when pcpi_wait=1 and increments otherwise.
  - pcpi_ready=1: capture rd and wr into the response register, status = {5'b0, timeout=0, wr, ready=1}, go to RESP.
  - Counter reaches TIMEOUT_CYCLES with pcpi_ready=0: rd=0, status = 8'h04 (timeout bit only), go to RESP.
  - pcpi_ready and timeout in the same cycle: pcpi_ready wins.
  - pcpi_wait high holds ISSUE indefinitely.
- RESP:
  - out_valid=1; emit status, then rd[7:0], rd[15:8], rd[23:16], rd[31:24].
  - out_data changes only after a handshake.
  - After the 5th handshake: counters clear, state returns to LOAD.
- pcpi_ready/pcpi_wait outside ISSUE are ignored.
- in_valid outside LOAD is ignored; no byte is consumed.

## Timing
- Reset values: state LOAD, in_ready=1, out_valid=0, out_data=0, pcpi_valid=0, pcpi_insn/rs1/rs2=0, busy=0, all counters 0.
- pcpi_valid rises the cycle after byte 11 is accepted.
- pcpi_valid falls the cycle after pcpi_ready is sampled high, or after the timeout cycle; out_valid rises in that same cycle.
- Minimum latency from pcpi_ready to first response byte: 1 cycle.
- Timeout with wait never asserted: pcpi_valid is high for exactly TIMEOUT_CYCLES cycles.
- With out_ready tied high, the response takes 5 cycles; the next frame's byte 0 is accepted the following cycle.
- Reset asserted mid-frame or mid-transaction: all state returns to reset values immediately.
  - Partial request bytes and a pending response are discarded.
  - pcpi_valid drops asynchronously.
- Counter widths: byte counter 4 bits; timeout counter $clog2(TIMEOUT_CYCLES+1) bits, saturating.

## Structure
- Shared package pcpi_pkg holds:
  - the state enum (LOAD, ISSUE, RESP);
  - REQ_BYTES=12 and RSP_BYTES=5;
  - status bit positions ST_READY=0, ST_WR=1, ST_TIMEOUT=2.
- Sub-module pcpi_timeout_ctr (clear, enable, expired) isolates the wait/timeout rule; the coprocessor wrapper reuses it.
- Everything else is flat in this module.

## Test plan
- Basic op: send insn 0x0200_00B3 with rs1=0x0000_0007, rs2=0x0000_0006; responder asserts ready with wr=1, rd=0x2A after 3 cycles → output bytes 03 2A 00 00 00.
- Unclaimed instruction: send any 12 bytes, responder silent → pcpi_valid high exactly 16 cycles, output 04 00 00 00 00.
- Long wait: responder holds pcpi_wait for 40 cycles, then ready with wr=0, rd=0xDEADBEEF → no timeout, output 01 EF BE AD DE.
- Ready on the timeout cycle: pcpi_ready first asserted on the 16th unwaited cycle → status 0x01 or 0x03, never 0x04.
- Backpressure: out_ready toggles 1-0-0-1; in_valid held high during RESP → each byte is held stable until its handshake, and no input byte is consumed before the 5th output handshake.
- Reset mid-stream: assert rst_n=0 after 7 request bytes, release, send a full basic-op frame → correct response 03 2A 00 00 00, with no residue from the partial frame.
